// File: rtl/akp_stream_packer.sv
// akp_stream_packer
// Output stage of the AKP compensation core. Buffers 192-bit result entries
// {UP_RE,UP_IM,DN_RE,DN_IM,PEL_RE,PEL_IM} framed by sop/eop in a small FIFO and
// serialises each line as a 32-bit ready/valid packet:
//   header {HDR_TAG, seq, 4'h0, len} followed by 6 words per entry.
// The AKP pipeline is never stalled. Dropped entries raise the sticky ovf flag,
// and framing problems raise the sticky frm_err flag.
// Optional build macro AKP_PACK_CHK_EN: adds a trailing XOR checksum word
// (header ^ all data words) that carries out_last.
module akp_stream_packer #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic           clk,
  input  logic           nclr,
  input  logic           in_ink,
  input  logic           in_valid,
  input  logic           in_sop,
  input  logic           in_eop,
  input  logic [191:0]   in_data,
  input  logic [11:0]    in_len,
  output logic [31:0]    out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sop,
  output logic           out_last,
  output logic [AW:0]    fifo_level,
  output logic           ovf,
  output logic           frm_err
);

  localparam int          EW       = 194;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
`ifdef AKP_PACK_CHK_EN
    S_DATA,
    S_CHK
`else
    S_DATA
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_level;
  logic           r_ovf;
  logic [11:0]    r_len;

  // Serialiser state and registered outputs
  state_t         r_state;
  logic [2:0]     r_idx;
  logic           r_out_valid;
  logic           r_out_sop;
  logic           r_out_last;
  logic [31:0]    r_out_data;
  logic [7:0]     r_seq;
  logic           r_frm_err;
`ifdef AKP_PACK_CHK_EN
  logic [31:0]    r_chk;
`endif

  logic           w_empty;
  logic           w_full;
  logic           w_has_next;
  logic           w_push;
  logic           w_pop;
  logic           w_wr_en;
  logic [AW-1:0]  w_wr_addr;
  logic [AW-1:0]  w_rd_nxt;
  logic [EW-1:0]  w_head;
  logic           w_head_sop;
  logic           w_head_eop;
  logic           w_next_sop;
  logic [31:0]    w_next_word0;
  logic [31:0]    w_head_word [6];
  logic [31:0]    w_step_word;
  logic           w_xfer;
  logic [31:0]    w_hdr_word;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_has_next = (r_level > LVL_ONE);
  assign w_push     = in_valid & ~w_full;
  // A flush frees the whole FIFO, so an entry arriving with in_ink always fits.
  assign w_wr_en    = in_valid & (in_ink | ~w_full);
  assign w_wr_addr  = in_ink ? '0 : r_wr_ptr;
  assign w_rd_nxt   = r_rd_ptr + AW'(1);

  // Head and look-ahead entries are read combinationally so the serialiser can
  // react in the cycle after a push and chain entries without a bubble.
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_sop   = w_head[193];
  assign w_head_eop   = w_head[192];
  assign w_next_sop   = r_mem[w_rd_nxt][193];
  assign w_next_word0 = r_mem[w_rd_nxt][191:160];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_word
      assign w_head_word[gi] = w_head[191-32*gi -: 32];
    end
  endgenerate

  assign w_xfer     = r_out_valid & out_ready;
  assign w_hdr_word = {HDR_TAG, r_seq, 4'h0, r_len};

  // Word following the one currently presented, within the head entry
  always_comb begin
    w_step_word = w_head_word[0];
    case (r_idx)
      3'd0:    w_step_word = w_head_word[1];
      3'd1:    w_step_word = w_head_word[2];
      3'd2:    w_step_word = w_head_word[3];
      3'd3:    w_step_word = w_head_word[4];
      3'd4:    w_step_word = w_head_word[5];
      default: w_step_word = w_head_word[0];
    endcase
  end

  // Pop: discard a stray head in IDLE, or retire the head after its last word
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = ~w_empty & ~w_head_sop;
      S_DATA:  w_pop = w_xfer & (r_idx == 3'd5);
      default: w_pop = 1'b0;
    endcase
  end

  // Entry storage write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= {in_sop, in_eop, in_data};
    end
  end

  // Line length captured with every sop entry
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_len <= '0;
    end else if (in_valid & in_sop) begin
      r_len <= in_len;
    end
  end

  // FIFO pointers, level and overflow flag; flush keeps a same-cycle write
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else if (in_ink) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= in_valid ? AW'(1) : '0;
      r_level  <= in_valid ? LVL_ONE : '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      if (w_push & ~w_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (~w_push & w_pop) begin
        r_level <= r_level - LVL_ONE;
      end
      if (in_valid & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Packet serialiser: header, 6 words per entry, optional checksum
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_seq       <= '0;
      r_frm_err   <= 1'b0;
`ifdef AKP_PACK_CHK_EN
      r_chk       <= '0;
`endif
    end else if (in_ink) begin
      // Truncate any packet in flight; the sequence number carries on.
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_frm_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_head_sop) begin
              r_state     <= S_HDR;
              r_out_valid <= 1'b1;
              r_out_sop   <= 1'b1;
              r_out_last  <= 1'b0;
              r_out_data  <= w_hdr_word;
            end else begin
              r_frm_err <= 1'b1;
            end
          end
        end

        S_HDR: begin
          if (w_xfer) begin
            r_state    <= S_DATA;
            r_idx      <= '0;
            r_seq      <= r_seq + 8'd1;
            r_out_sop  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_data <= w_head_word[0];
`ifdef AKP_PACK_CHK_EN
            r_chk      <= r_out_data;
`endif
          end
        end

        S_DATA: begin
          if (!r_out_valid) begin
            // Mid-packet starvation: resume as soon as an entry arrives.
            if (!w_empty) begin
              r_out_valid <= 1'b1;
              r_idx       <= '0;
              if (w_head_sop) begin
                r_frm_err  <= 1'b1;
                r_state    <= S_HDR;
                r_out_sop  <= 1'b1;
                r_out_data <= w_hdr_word;
              end else begin
                r_out_data <= w_head_word[0];
              end
            end
          end else if (w_xfer) begin
`ifdef AKP_PACK_CHK_EN
            r_chk <= r_chk ^ r_out_data;
`endif
            if (r_idx != 3'd5) begin
              r_idx      <= r_idx + 3'd1;
              r_out_data <= w_step_word;
`ifndef AKP_PACK_CHK_EN
              r_out_last <= (r_idx == 3'd4) & w_head_eop;
`endif
            end else if (w_head_eop) begin
`ifdef AKP_PACK_CHK_EN
              r_state    <= S_CHK;
              r_out_data <= r_chk ^ r_out_data;
              r_out_last <= 1'b1;
`else
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
`endif
            end else if (w_has_next) begin
              r_idx <= '0;
              if (w_next_sop) begin
                // New line started before this one ended: close it unmarked.
                r_frm_err  <= 1'b1;
                r_state    <= S_HDR;
                r_out_sop  <= 1'b1;
                r_out_data <= w_hdr_word;
              end else begin
                r_out_data <= w_next_word0;
              end
            end else begin
              r_idx       <= '0;
              r_out_valid <= 1'b0;
            end
          end
        end

`ifdef AKP_PACK_CHK_EN
        S_CHK: begin
          if (w_xfer) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_sop    = r_out_sop;
  assign out_last   = r_out_last;
  assign fifo_level = r_level;
  assign ovf        = r_ovf;
  assign frm_err    = r_frm_err;

endmodule
